// File: rtl/select_rd.sv
// select_rd: load-data alignment and sign/zero extension for the memory
// writeback path, plus a sticky misaligned-load flag for the trap logic.
// Optional build macro SELECT_RD_REG_OUT_EN registers rd_mem (one cycle
// latency, async reset to 0); when undefined rd_mem is combinational.
module select_rd #(
   parameter int REG_LEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_LEN-1:0] rdata,
   input  logic [2:0]         sel_type,
   input  logic [1:0]         sel_addr_old,
   input  logic               ld_en,
   input  logic               clr_err,
   output logic [REG_LEN-1:0] rd_mem,
   output logic               misalign,
   output logic               misalign_err
);

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

   logic        [7:0]         byte_lane_p0;
   logic        [15:0]        half_lane_p0;
   logic        [REG_LEN-1:0] ext_p0;

   // Byte to register width; sign bit replicated only for signed loads.
   function automatic logic [REG_LEN-1:0] ext_byte(input logic signed [7:0] b,
                                                   input logic sgn);
      return {{(REG_LEN-8){sgn & b[7]}}, b};
   endfunction

   // Halfword to register width; sign bit replicated only for signed loads.
   function automatic logic [REG_LEN-1:0] ext_half(input logic signed [15:0] h,
                                                   input logic sgn);
      return {{(REG_LEN-16){sgn & h[15]}}, h};
   endfunction

   // Little-endian lane select; halfword uses only address bit 1.
   always_comb begin
      byte_lane_p0 = rdata[7:0];
      case (sel_addr_old)
         2'b00:   byte_lane_p0 = rdata[7:0];
         2'b01:   byte_lane_p0 = rdata[15:8];
         2'b10:   byte_lane_p0 = rdata[23:16];
         default: byte_lane_p0 = rdata[31:24];
      endcase
      half_lane_p0 = sel_addr_old[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension by load type; reserved encodings return zero.
   always_comb begin
      ext_p0 = '0;
      case (sel_type)
         LD_B:    ext_p0 = ext_byte(byte_lane_p0, 1'b1);
         LD_H:    ext_p0 = ext_half(half_lane_p0, 1'b1);
         LD_W:    ext_p0 = rdata;
         LD_BU:   ext_p0 = ext_byte(byte_lane_p0, 1'b0);
         LD_HU:   ext_p0 = ext_half(half_lane_p0, 1'b0);
         default: ext_p0 = '0;
      endcase
   end

   // Alignment check: halfwords need bit 0 clear, words need both bits clear.
   always_comb begin
      misalign = 1'b0;
      case (sel_type)
         LD_H, LD_HU: misalign = sel_addr_old[0];
         LD_W:        misalign = (sel_addr_old != 2'b00);
         default:     misalign = 1'b0;
      endcase
   end

   // Sticky error: clear wins over a simultaneous misaligned consume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         misalign_err <= 1'b0;
      else if (clr_err)
         misalign_err <= 1'b0;
      else if (ld_en && misalign)
         misalign_err <= 1'b1;
   end

`ifdef SELECT_RD_REG_OUT_EN
   logic [REG_LEN-1:0] rd_mem_p1;

   // Output register loads every cycle, independent of ld_en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_mem_p1 <= '0;
      else
         rd_mem_p1 <= ext_p0;
   end

   assign rd_mem = rd_mem_p1;
`else
   assign rd_mem = ext_p0;
`endif

endmodule

// File: tb/tb_select_rd.sv
// tb_select_rd: directed vectors for select_rd; the driver queues expected
// results and a negedge monitor pops and compares them.
module tb_select_rd;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rdata = '0;
   logic [2:0]  sel_type = '0;
   logic [1:0]  sel_addr_old = '0;
   logic        ld_en = 1'b0;
   logic        clr_err = 1'b0;
   logic [31:0] rd_mem;
   logic        misalign;
   logic        misalign_err;

   select_rd #(.REG_LEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdata        (rdata),
      .sel_type     (sel_type),
      .sel_addr_old (sel_addr_old),
      .ld_en        (ld_en),
      .clr_err      (clr_err),
      .rd_mem       (rd_mem),
      .misalign     (misalign),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] rd;
      logic        mis;
      logic        err;
      logic        rst_rd;
   } ent_t;

   ent_t mis_q[$];
   ent_t rd_q[$];

   int n_vec = 0;
   int n_err = 0;
   logic chk = 1'b0;
   logic chk_d = 1'b0;
   logic rd_chk;

   always @(posedge clk) chk_d <= chk;

`ifdef SELECT_RD_REG_OUT_EN
   assign rd_chk = chk_d;
`else
   assign rd_chk = chk;
`endif

   task automatic cmp(input string tag, input string what,
                      input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %08h expected %08h", tag, what, act, exp);
      end
   endtask

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;

   // Drive one vector just after posedge and queue what it should produce.
   task automatic apply(input string tag, input logic [2:0] ty, input logic [1:0] ad,
                        input logic [31:0] d, input logic ld, input logic clr,
                        input logic r, input logic [31:0] exp_rd,
                        input logic exp_mis, input logic exp_err);
      ent_t e;
      @(posedge clk);
      #1;
      sel_type = ty; sel_addr_old = ad; rdata = d; ld_en = ld; clr_err = clr;
      rst = r;
      e.tag = tag; e.rd = exp_rd; e.mis = exp_mis; e.err = exp_err; e.rst_rd = r;
      mis_q.push_back(e);
      rd_q.push_back(e);
      chk = 1'b1;
      if (r) begin
         @(negedge clk);
         #1 rst = 1'b0;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      chk = 1'b0; ld_en = 1'b0; clr_err = 1'b0;
   endtask

   // Monitor: misalign/err are checked in the drive cycle, rd_mem after its latency.
   always @(negedge clk) begin
      ent_t e;
      if (chk) begin
         if (mis_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mis_q underflow");
         end else begin
            e = mis_q.pop_front();
            cmp(e.tag, "misalign", {31'd0, misalign}, {31'd0, e.mis});
            cmp(e.tag, "misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
`ifdef SELECT_RD_REG_OUT_EN
            if (e.rst_rd) cmp(e.tag, "rd_mem_in_reset", rd_mem, 32'h0);
`endif
         end
      end
      if (rd_chk) begin
         if (rd_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rd_q underflow");
         end else begin
            e = rd_q.pop_front();
            cmp(e.tag, "rd_mem", rd_mem, e.rd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      // tag             type  ad     rdata         ld    clr   rst   rd_mem        mis   err
      apply("rst_lbu",   LBU, 2'b10, 32'h00FF0000, 1'b0, 1'b0, 1'b1, 32'h000000FF, 1'b0, 1'b0);
      apply("lb_a10",    LB,  2'b10, 32'h00FF0000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      apply("lhu_a10",   LHU, 2'b10, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00001234, 1'b0, 1'b0);
      apply("lhu_a00",   LHU, 2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00005678, 1'b0, 1'b0);
      apply("lh_a10",    LH,  2'b10, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00001234, 1'b0, 1'b0);
      apply("lh_a00",    LH,  2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00005678, 1'b0, 1'b0);
      apply("lb_a11",    LB,  2'b11, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000012, 1'b0, 1'b0);
      apply("lb_a10b",   LB,  2'b10, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000034, 1'b0, 1'b0);
      apply("lb_a01",    LB,  2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000056, 1'b0, 1'b0);
      apply("lb_a00",    LB,  2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000078, 1'b0, 1'b0);
      apply("lbu_a11",   LBU, 2'b11, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000012, 1'b0, 1'b0);
      apply("lbu_a10",   LBU, 2'b10, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000034, 1'b0, 1'b0);
      apply("lbu_a01",   LBU, 2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000056, 1'b0, 1'b0);
      apply("lbu_a00",   LBU, 2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000078, 1'b0, 1'b0);
      apply("lw_a00",    LW,  2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
      apply("lh_neg",    LH,  2'b10, 32'h80008000, 1'b0, 1'b0, 1'b0, 32'hFFFF8000, 1'b0, 1'b0);
      apply("lhu_neg",   LHU, 2'b10, 32'h80008000, 1'b0, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b0);
      apply("rsv_111",   3'd7, 2'b10, 32'h80008000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
      apply("lw_mis_nold", LW, 2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0);
      apply("lh_mis_ld", LH,  2'b01, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h00005678, 1'b1, 1'b0);
      apply("lh_set",    LH,  2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00005678, 1'b1, 1'b1);
      apply("err_hold",  LBU, 2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000056, 1'b0, 1'b1);
      apply("clr_and_set", LHU, 2'b11, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h00001234, 1'b1, 1'b1);
      apply("clr_wins",  LBU, 2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000078, 1'b0, 1'b0);
      apply("lw_mis_a10", LW, 2'b10, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0);
      apply("lw_set",    LW,  2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1);
      apply("clr_only",  LB,  2'b00, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h00000078, 1'b0, 1'b1);
      apply("cleared",   LB,  2'b00, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000078, 1'b0, 1'b0);
      apply("lhu_mis_ld", LHU, 2'b11, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h00001234, 1'b1, 1'b0);
      apply("rsv_101",   3'd5, 2'b01, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1);
      idle();
      apply("async_rst", LH,  2'b01, 32'h80008000, 1'b0, 1'b0, 1'b1, 32'hFFFF8000, 1'b1, 1'b0);
      apply("lw_dead",   LW,  2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      apply("lb_byte_ld", LB, 2'b11, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b0);
      apply("byte_noset", LW, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      idle();
      idle();
      @(negedge clk);
      cmp("drain", "mis_q_left", mis_q.size(), 32'd0);
      cmp("drain", "rd_q_left", rd_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/select_rd.md
Name: select_rd

Overview:
- Load-data alignment and extension unit in the core's memory writeback path.
- Takes the raw 32-bit word read from data memory and the load type and low address bits latched with the request (`sel_addr_old`).
- Returns the byte, halfword or word as a right-justified, sign- or zero-extended register value `rd_mem`.
- Also keeps a registered sticky misaligned-load flag for the trap logic.

Parameters:
- REG_LEN, 32, data path width; byte/halfword lanes assume 32.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-high
- rdata  input  REG_LEN  raw word returned by data memory
- sel_type  input  3  load type: 000 LB (signed byte), 001 LH (signed half), 010 LW, 011 LBU, 100 LHU
- sel_addr_old  input  2  low address bits of the load, registered by the requester with the request
- ld_en  input  1  a load result is being consumed this cycle (qualifies error capture)
- clr_err  input  1  synchronous clear of the sticky error flag
- rd_mem  output  REG_LEN  extended load result
- misalign  output  1  combinational: current sel_type/sel_addr_old is misaligned
- misalign_err  output  1  registered sticky misalignment flag

Behaviour:
- Byte lanes are little-endian: addr 00 selects rdata[7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24].
- Halfword select uses sel_addr_old[1] only: 0 → rdata[15:0], 1 → rdata[31:16]; bit 0 is ignored for data.
- Word load: rd_mem = rdata for any address.
- Signed types (000, 001) replicate the selected MSB into the upper bits; unsigned types (011, 100) zero-fill.
- Reserved sel_type 101/110/111: rd_mem = 0, misalign = 0.
- rd_mem is purely combinational from rdata, sel_type and sel_addr_old (zero latency, no clock dependence) unless the optional feature is enabled.
- misalign = 1 for halfword types with sel_addr_old[0] = 1, or for LW with sel_addr_old != 00. Byte types are never misaligned.
- misalign_err register behaviour:
  - Reset value 0 (asynchronous).
  - On each rising clk: if clr_err, clear to 0; else if ld_en & misalign, set to 1; else hold.
  - clr_err has priority over a simultaneous set.
- Misaligned loads still produce data per the lane rules above; no masking.
- Reset mid-operation affects only registered state; the combinational rd_mem path is unaffected.

Optional Feature:
- Macro SELECT_RD_REG_OUT_EN.
- Defined:
  - rd_mem is registered on rising clk, so results appear one cycle after inputs.
  - Asynchronous reset drives rd_mem to 0.
  - The register loads every cycle regardless of ld_en.
- Undefined: rd_mem is combinational as specified above.
- misalign and misalign_err behave identically in both builds.

Test Plan:
- rdata=0x00FF0000, LBU, addr 10 → rd_mem=0x000000FF; same with LB → 0xFFFFFFFF.
- rdata=0x12345678, LHU addr 10 → 0x00001234; addr 00 → 0x00005678; LH at same addrs → same values (positive MSB).
- rdata=0x12345678, LB and LBU at addr 11/10/01/00 → 0x12, 0x34, 0x56, 0x78 zero-extended; LW addr 00 → 0x12345678.
- rdata=0x80008000: LH addr 10 → 0xFFFF8000; LHU addr 10 → 0x00008000; sel_type=111 → 0x00000000.
- Misalignment: LH addr 01 → misalign=1; with ld_en=1 on a clk edge, misalign_err=1 and holds after ld_en drops. Assert clr_err and ld_en&misalign together → misalign_err=0. Async rst mid-cycle → misalign_err=0 immediately.
- SELECT_RD_REG_OUT_EN build: rd_mem=0 during rst. Apply LW 0xDEADBEEF → rd_mem updates only after the next rising clk.
